// File: rtl/tick_sequencer_pkg.sv
// Shared types and constants for the tick sequencer.
// Holds the state encoding and the configuration values loaded at reset.
package tick_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_P = 1;
  localparam int unsigned DEF_B = 0;

endpackage

// File: rtl/tick_sequencer_period_counter.sv
// Free-running period counter for the tick sequencer.
// Raises a combinational wrap on the cycle it holds P-1 while enabled.
module period_counter
  import tick_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority so a new run always starts counting from zero.
  always_comb begin
    wrap  = enable && (cnt_q == (period - CNT_W'(1)));
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tick_sequencer.sv
// Programmable tick scheduler: emits one-cycle tick enables every P cycles,
// either continuously or for a burst of B ticks, then pulses done.
module tick_sequencer
  import tick_sequencer_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               tick,
  output logic               phase,
  output logic               busy,
  output logic               done
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     p_q, p_d;
  logic [BURST_W-1:0]   b_q, b_d;
  logic [BURST_W-1:0]   bcnt_q, bcnt_d;
  logic                 tick_q, tick_d;
  logic                 phase_q, phase_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cnt_clear;
  logic                 cnt_en;
  logic                 wrap;

  assign cfg_ready = (state_q == ST_IDLE);
  assign tick      = tick_q;
  assign phase     = phase_q;
  assign busy      = busy_q;
  assign done      = done_q;

  period_counter #(.CNT_W(CNT_W)) u_period_counter (
    .clk    (CLK),
    .rst_n  (RST_N),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .period (p_q),
    .wrap   (wrap)
  );

  // Config capture, run control and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    b_d       = b_q;
    bcnt_d    = bcnt_q;
    tick_d    = 1'b0;
    phase_d   = phase_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;

    // A divider of zero behaves as one so the counter always wraps.
    if (cfg_valid && cfg_ready) begin
      p_d = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
      b_d = cfg_burst;
    end else begin
      p_d = p_q;
      b_d = b_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          cnt_clear = 1'b1;
          bcnt_d    = '0;
          phase_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Stop beats a tick falling due on the same edge.
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
          if (wrap) begin
            tick_d  = 1'b1;
            phase_d = ~phase_q;
            if (b_q != '0) begin
              bcnt_d = bcnt_q + BURST_W'(1);
              if (bcnt_q == (b_q - BURST_W'(1))) begin
                state_d = ST_DONE;
              end else begin
                state_d = ST_RUN;
              end
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_q == ST_DONE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      p_q     <= CNT_W'(DEF_P);
      b_q     <= BURST_W'(DEF_B);
      bcnt_q  <= '0;
      tick_q  <= 1'b0;
      phase_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      b_q     <= b_d;
      bcnt_q  <= bcnt_d;
      tick_q  <= tick_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_tick_sequencer.sv
// Self-checking bench for tick_sequencer: an edge-counting run model checked
// every cycle, plus directed runs with hand-computed tick/done positions.
module tb_tick_sequencer;

  localparam int CNT_W   = 16;
  localparam int BURST_W = 8;

  logic               CLK       = 1'b0;
  logic               RST_N     = 1'b0;
  logic               cfg_valid = 1'b0;
  logic [CNT_W-1:0]   cfg_div   = '0;
  logic [BURST_W-1:0] cfg_burst = '0;
  logic               start     = 1'b0;
  logic               stop      = 1'b0;
  logic               cfg_ready, tick, phase, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  tick_sequencer #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_burst (cfg_burst),
    .start     (start),
    .stop      (stop),
    .tick      (tick),
    .phase     (phase),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is described by the number of edges since start (m_k),
  // its period and burst; outputs follow from plain arithmetic on those.
  bit m_started = 1'b0;
  bit m_stopped = 1'b0;
  int m_k = 0, m_stopk = 0, m_P = 1, m_B = 0, cfg_P = 1, cfg_B = 0;

  function automatic bit m_ready();
    return !m_started || m_stopped || (m_B != 0 && m_k >= m_B * m_P + 1);
  endfunction

  function automatic bit m_running();
    return m_started && !m_stopped && (m_B == 0 || m_k < m_B * m_P);
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    bit rdy, run;
    if (!RST_N) begin
      m_started = 1'b0; m_stopped = 1'b0; m_k = 0; m_stopk = 0;
      m_P = 1; m_B = 0; cfg_P = 1; cfg_B = 0;
    end else begin
      rdy = m_ready();
      run = m_running();
      if (rdy && cfg_valid) begin
        cfg_P = (cfg_div == '0) ? 1 : int'(cfg_div);
        cfg_B = int'(cfg_burst);
      end
      if (rdy && start) begin
        m_started = 1'b1; m_stopped = 1'b0; m_k = 0; m_P = cfg_P; m_B = cfg_B;
      end else begin
        if (run && stop) begin
          m_stopped = 1'b1;
          m_stopk   = m_k + 1;
        end
        m_k++;
      end
    end
  end

  always @(posedge CLK) begin
    int eff, n;
    bit e_tick, e_phase, e_busy, e_done, e_ready;
    #1;
    if (RST_N) begin
      if (!m_started) begin
        e_tick = 1'b0; e_phase = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_ready = 1'b1;
      end else begin
        eff = m_stopped ? m_stopk - 1 : m_k;
        n   = eff / m_P;
        if (m_B != 0 && n > m_B) n = m_B;
        e_tick  = !m_stopped && m_k > 0 && (m_k % m_P == 0) && (m_B == 0 || m_k / m_P <= m_B);
        e_phase = n[0];
        e_busy  = !m_stopped && (m_B == 0 || m_k < m_B * m_P);
        e_done  = !m_stopped && m_B != 0 && m_k == m_B * m_P + 1;
        e_ready = m_ready();
      end
      check("mdl_tick", tick, e_tick);
      check("mdl_phase", phase, e_phase);
      check("mdl_busy", busy, e_busy);
      check("mdl_done", done, e_done);
      check("mdl_cfg_ready", cfg_ready, e_ready);
    end
  end

  task automatic offer(input int div, input int burst, input logic st);
    cfg_valid = 1'b1;
    cfg_div   = CNT_W'(div);
    cfg_burst = BURST_W'(burst);
    start     = st;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_tick", tick, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_phase", phase, 1'b0);
    check("rst_ready", cfg_ready, 1'b1);
    RST_N = 1'b1;
    @(negedge CLK);

    // P=4, B=3: ticks after edges 4, 8, 12; done after 13.
    offer(4, 3, 1'b1);
    @(negedge CLK);
    cfg_valid = 1'b0; start = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge CLK);
      check("t1_tick", tick, (i == 4 || i == 8 || i == 12));
      check("t1_done", done, (i == 13));
    end
    check("t1_busy_end", busy, 1'b0);
    check("t1_phase_end", phase, 1'b1);
    check("t1_ready_end", cfg_ready, 1'b1);

    // P=0 behaves as 1, continuous; stop sampled on the sixth edge.
    offer(0, 0, 1'b1);
    @(negedge CLK);
    cfg_valid = 1'b0; start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge CLK);
      check("t2_tick", tick, 1'b1);
    end
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    check("t2_stop_tick", tick, 1'b0);
    check("t2_stop_done", done, 1'b0);
    check("t2_stop_ready", cfg_ready, 1'b1);
    check("t2_stop_busy", busy, 1'b0);
    check("t2_phase_hold", phase, 1'b1);
    repeat (2) @(negedge CLK);
    check("t2_quiet", tick, 1'b0);

    // P=3 continuous; a config offered during RUN must be refused.
    offer(3, 0, 1'b1);
    @(negedge CLK);
    cfg_valid = 1'b0; start = 1'b0;
    offer(10, 1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      if (i == 2) cfg_valid = 1'b0;
      check("t3_ready_run", cfg_ready, 1'b0);
      check("t3_tick", tick, (i % 3 == 0));
    end
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    check("t3_stop_on_tick", tick, 1'b0);
    check("t3_idle", cfg_ready, 1'b1);
    check("t3_phase", phase, 1'b0);

    // Config and start on the same edge: P=10, B=1 applies at once.
    offer(10, 1, 1'b1);
    @(negedge CLK);
    cfg_valid = 1'b0; start = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge CLK);
      check("t3b_tick", tick, (i == 10));
      check("t3b_done", done, (i == 11));
    end

    // Reset mid-burst after three ticks, then a full 8-tick run at P=1.
    offer(2, 8, 1'b1);
    @(negedge CLK);
    cfg_valid = 1'b0; start = 1'b0;
    repeat (6) @(negedge CLK);
    check("t4_tick_pre", tick, 1'b1);
    check("t4_phase_pre", phase, 1'b1);
    check("t4_busy_pre", busy, 1'b1);
    RST_N = 1'b0;
    #1;
    check("t4_rst_tick", tick, 1'b0);
    check("t4_rst_busy", busy, 1'b0);
    check("t4_rst_phase", phase, 1'b0);
    check("t4_rst_done", done, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    offer(0, 8, 1'b1);
    @(negedge CLK);
    cfg_valid = 1'b0; start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      check("t4_tick", tick, (i <= 8));
      check("t4_done", done, (i == 9));
    end

    // start held high: next run begins on the edge after done.
    offer(2, 2, 1'b1);
    @(negedge CLK);
    cfg_valid = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      check("t5_tick", tick, (i == 2 || i == 4 || i == 8 || i == 10));
      check("t5_done", done, (i == 5 || i == 11));
      check("t5_busy", busy, !(i == 4 || i == 5 || i == 10 || i == 11));
    end
    start = 1'b0;
    repeat (8) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tick_sequencer.md
# tick_sequencer

Programmable tick scheduler that sequences the system clock resource into timed enable pulses for downstream datapath blocks. It accepts a divider/burst configuration through a valid/ready handshake. On start it emits one-cycle `tick` enables every P cycles, either continuously or for a fixed burst count, then reports completion. It sits directly downstream of the clock source and gates the pace of counters, displays and debouncers in the lab designs.

## Interface
- `CNT_W`, 16, width of divider/period counter
- `BURST_W`, 8, width of burst count

- `CLK` in 1: system clock, all logic on rising edge
- `RST_N` in 1: reset, asynchronous and active-low
- `cfg_valid` in 1: configuration offered
- `cfg_ready` out 1: configuration accepted this edge if `cfg_valid`; equals (state == IDLE)
- `cfg_div` in CNT_W: tick period P; 0 treated as 1
- `cfg_burst` in BURST_W: ticks per run B; 0 = continuous
- `start` in 1: begin a run (honoured only in IDLE)
- `stop` in 1: abort a run (honoured only in RUN)
- `tick` out 1: registered one-cycle enable pulse
- `phase` out 1: toggles on every tick (square wave of period 2P)
- `busy` out 1: high in RUN
- `done` out 1: one-cycle pulse when a burst completes

## Operation
- States: IDLE, RUN, DONE. All outputs registered except `cfg_ready`.
- Reset (`RST_N` low, any time): state IDLE, `tick`=0, `phase`=0, `busy`=0, `done`=0, stored P=1, B=0, period and tick counters 0. `cfg_ready`=1.
- Config: latched on an edge with `cfg_valid && cfg_ready`. Config and `start` on the same edge: the new config is used for that run.
- IDLE + `start`: go to RUN. Clear the period counter, tick counter and `phase`. `busy`=1 from the next cycle.
- RUN: the period counter increments each edge. On reaching P-1 it wraps to 0 and `tick` is set for one cycle. `phase` toggles and the tick counter increments (when B≠0).
- Burst end: the edge that sets the B-th `tick` also moves the state to DONE. In DONE, `done`=1 and `busy`=0 for one cycle, then IDLE.
- B=0: RUN continues until `stop`. The tick counter is not used.
- RUN + `stop`: go to IDLE at that edge. `stop` wins over a tick due at the same edge (no tick, no phase toggle). `done` is not asserted. `phase` holds its value.
- `start` while in RUN or DONE: ignored. `stop` in IDLE or DONE: ignored.
- Period counter arithmetic is unsigned modulo 2^CNT_W. P ranges 1..2^CNT_W-1.

## Timing
- First `tick` is high in the cycle following the P-th rising edge after the edge that samples `start`. Subsequent ticks follow every P edges.
- P=1: `tick` is high every cycle while in RUN.
- Last burst tick and `done` are in consecutive cycles. A new `start` is accepted the edge after `done` deasserts (IDLE).
- Start-to-start minimum for a burst is B·P+2 cycles.
- An asynchronous reset mid-run forces all outputs to their reset values immediately. No `done` is produced.

## Structure
- Shared package `tick_sequencer_pkg`: state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default P/B constants.
- Sub-module `period_counter`:
  - Inputs: clear, enable, P.
  - Output: `wrap` pulse.
  - Instantiated once. FSM, burst counter and output registers live in the top.

## Test plan
- Reset then P=4, B=3, start → ticks at edges 4, 8, 12 after start; `done` one cycle after the third; `busy` low afterward; `phase` ends 1.
- P=0 (treated as 1), B=0, start, stop after 5 edges → 5 consecutive ticks, then none; no `done`; `cfg_ready` returns 1.
- P=3, B=0, `stop` asserted on the edge a tick is due → no tick at that edge; state IDLE.
- `cfg_valid` during RUN with P=10 → `cfg_ready`=0, config not latched, period stays 3. `cfg_valid` + `start` together in IDLE → P=10 applies immediately.
- `RST_N` pulsed low mid-burst (P=2, B=8, after 3 ticks) → `tick`, `busy`, `phase` drop at once; no `done`; next start runs a full 8 ticks with P=1 default.
- `start` held high through an entire run (P=2, B=2) → second run begins the edge after `done`; no start accepted during RUN/DONE.
